// File: rtl/usb_stream_in.sv
// usb_stream_in: buffers a 16-bit fabric stream and writes it into FX2 EP6 IN (synchronous slave FIFO).
// Optional idle-timeout short-packet commit is enabled by defining USB_STREAM_IN_TIMEOUT_EN.
module usb_stream_in #(
    parameter int FIFO_AW        = 4,
    parameter int PKT_WORDS      = 256,
    parameter int FLAG_LAT       = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        fx2_ifclk,
    input  logic        reset_n,
    input  logic [15:0] data_in,
    input  logic        data_valid,
    output logic        data_ready,
    input  logic        flush,
    input  logic        fx2_flagb,
    output logic [15:0] fx2_fdata,
    output logic [1:0]  fx2_faddr,
    output logic        fx2_slwr,
    output logic        fx2_slrd,
    output logic        fx2_sloe,
    output logic        fx2_pkt_end,
    output logic        fx2_slcs,
    output logic        busy
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = FIFO_AW + 1;
    localparam int WC_W  = $clog2(PKT_WORDS + 1);
    localparam int LC_W  = $clog2(FLAG_LAT + 1);

    typedef enum logic [1:0] {IDLE, WRITE, COMMIT, FLAG_WAIT} state_t;
    state_t state, state_d;

    logic [15:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]      count, count_d;
    logic               push, pop, empty;
    logic               flag_q, flush_lat, flush_lat_d, flush_pend, timeout_hit;
    logic [WC_W-1:0]    wcnt, wcnt_d;
    logic [LC_W-1:0]    lat_cnt, lat_cnt_d;
    logic               slwr_d, pkt_end_d;
    logic [15:0]        fdata_d;

    assign push       = data_valid && data_ready;
    assign empty      = (count == '0);
    assign count_d    = count + CW'(push) - CW'(pop);
    assign flush_pend = flush_lat || flush;
    assign busy       = (state != IDLE) || !empty;

    assign fx2_faddr = 2'b10;
    assign fx2_slrd  = 1'b1;
    assign fx2_sloe  = 1'b1;
    assign fx2_slcs  = 1'b0;

    always_ff @(posedge fx2_ifclk) begin
        if (push) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge fx2_ifclk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            data_ready <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count      <= count_d;
            data_ready <= (count_d != CW'(DEPTH));
        end
    end

`ifdef USB_STREAM_IN_TIMEOUT_EN
    localparam int TC_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TC_W-1:0] idle_cnt;

    always_ff @(posedge fx2_ifclk or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt <= '0;
        end else if (push || pop || state == COMMIT) begin
            idle_cnt <= '0;
        end else if (state == IDLE && empty && wcnt != '0 && !timeout_hit) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign timeout_hit = (idle_cnt == TC_W'(TIMEOUT_CYCLES));
`else
    // No idle timer in this build: partial packets wait for data or flush.
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        state_d     = state;
        pop         = 1'b0;
        slwr_d      = 1'b1;
        pkt_end_d   = 1'b1;
        fdata_d     = fx2_fdata;
        wcnt_d      = wcnt;
        lat_cnt_d   = lat_cnt;
        flush_lat_d = flush_pend;
        case (state)
            IDLE: begin
                if (!empty && flag_q) begin
                    state_d = WRITE;
                end else if (empty && wcnt != '0 && (flush_pend || timeout_hit)) begin
                    state_d = COMMIT;
                end else if (empty && wcnt == '0) begin
                    flush_lat_d = 1'b0;
                end
            end
            WRITE: begin
                if (!empty && flag_q) begin
                    pop     = 1'b1;
                    slwr_d  = 1'b0;
                    fdata_d = mem[rd_ptr];
                    if (wcnt == WC_W'(PKT_WORDS - 1)) begin
                        // FX2 auto-commits this packet; a flush with nothing left behind it is moot.
                        wcnt_d  = '0;
                        state_d = FLAG_WAIT;
                        if (count == CW'(1) && !push) flush_lat_d = 1'b0;
                    end else begin
                        wcnt_d = wcnt + 1'b1;
                    end
                end else if (empty) begin
                    state_d = (flush_pend && wcnt != '0) ? COMMIT : IDLE;
                end
            end
            COMMIT: begin
                pkt_end_d   = 1'b0;
                wcnt_d      = '0;
                flush_lat_d = 1'b0;
                lat_cnt_d   = '0;
                state_d     = FLAG_WAIT;
            end
            FLAG_WAIT: begin
                if (lat_cnt == LC_W'(FLAG_LAT - 1)) begin
                    lat_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    lat_cnt_d = lat_cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge fx2_ifclk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            flag_q      <= 1'b0;
            flush_lat   <= 1'b0;
            wcnt        <= '0;
            lat_cnt     <= '0;
            fx2_slwr    <= 1'b1;
            fx2_pkt_end <= 1'b1;
            fx2_fdata   <= '0;
        end else begin
            state       <= state_d;
            flag_q      <= fx2_flagb;
            flush_lat   <= flush_lat_d;
            wcnt        <= wcnt_d;
            lat_cnt     <= lat_cnt_d;
            fx2_slwr    <= slwr_d;
            fx2_pkt_end <= pkt_end_d;
            fx2_fdata   <= fdata_d;
        end
    end
endmodule

// File: tb/tb_usb_stream_in.sv
// Testbench for usb_stream_in: a table of packet scenarios, corner-case sequences and a randomized
// run, all checked against a word-queue model of the traffic seen on the FX2 pins.
`timescale 1ns/1ps
module tb_usb_stream_in;
    localparam int PKT_WORDS = 256;
    localparam int FLAG_LAT  = 3;
`ifdef USB_STREAM_IN_TIMEOUT_EN
    localparam int TO_CYCLES = 16;
    localparam int TO_PKTS   = 1;
`else
    localparam int TO_CYCLES = 1024;
    localparam int TO_PKTS   = 0;
`endif
    localparam int NROWS = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] data_in;
    logic        data_valid;
    logic        data_ready;
    logic        flush;
    logic        fx2_flagb;
    logic [15:0] fx2_fdata;
    logic [1:0]  fx2_faddr;
    logic        fx2_slwr, fx2_slrd, fx2_sloe, fx2_pkt_end, fx2_slcs, busy;

    usb_stream_in #(
        .FIFO_AW(4), .PKT_WORDS(PKT_WORDS), .FLAG_LAT(FLAG_LAT), .TIMEOUT_CYCLES(TO_CYCLES)
    ) dut (
        .fx2_ifclk(clk), .reset_n(reset_n), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .flush(flush), .fx2_flagb(fx2_flagb), .fx2_fdata(fx2_fdata),
        .fx2_faddr(fx2_faddr), .fx2_slwr(fx2_slwr), .fx2_slrd(fx2_slrd), .fx2_sloe(fx2_sloe),
        .fx2_pkt_end(fx2_pkt_end), .fx2_slcs(fx2_slcs), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n;
        bit fl;
        int exp_wr;
        int exp_pe;
    } row_t;
    row_t rows[NROWS];

    int          errors = 0;
    int          checks = 0;
    logic [15:0] src_q[$];
    logic [15:0] sb_q[$];
    bit          src_en = 1'b1;
    int          pkt_words = 0;
    int          quiet = 0;
    int          n_wr = 0;
    int          n_pe = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Model: every write must carry the oldest accepted word; packets are closed by 256 writes or pkt_end.
    task automatic monitor();
        logic [15:0] exp_w;
        if (!reset_n) begin
            sb_q.delete();
            pkt_words = 0;
            quiet = 0;
            return;
        end
        if (quiet > 0) begin
            check("flag_wait_slwr_high", 32'(fx2_slwr), 32'd1);
            quiet--;
        end
        if (fx2_slwr === 1'b0) begin
            check("write_has_data", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                exp_w = sb_q.pop_front();
                check("fdata_order", 32'(fx2_fdata), 32'(exp_w));
            end
            n_wr++;
            pkt_words++;
            if (pkt_words == PKT_WORDS) begin
                pkt_words = 0;
                quiet = FLAG_LAT;
            end
        end
        if (fx2_pkt_end === 1'b0) begin
            check("pkt_end_slwr_exclusive", 32'(fx2_slwr), 32'd1);
            check("pkt_end_not_zero_length", 32'(pkt_words != 0), 32'd1);
            pkt_words = 0;
            n_pe++;
            quiet = FLAG_LAT;
        end
        if (data_valid && data_ready) begin
            sb_q.push_back(data_in);
            if (src_q.size() != 0) void'(src_q.pop_front());
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        flush      = 1'b0;
        data_valid = src_en && (src_q.size() != 0);
        data_in    = (src_q.size() != 0) ? src_q[0] : 16'h0;
    endtask

    task automatic run_until_idle(input string name);
        int guard;
        guard = 0;
        while ((src_q.size() != 0 || busy) && guard < 3000) begin
            cycle();
            guard++;
        end
        check({name, "_reached_idle"}, 32'(guard < 3000), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, p0, guard, stall_wr, seen_low;
        rows[0] = '{5,   1'b1, 5,   1};
        rows[1] = '{0,   1'b1, 0,   0};
        rows[2] = '{1,   1'b1, 1,   1};
        rows[3] = '{7,   1'b0, 7,   0};
        rows[4] = '{3,   1'b1, 3,   1};
        rows[5] = '{256, 1'b0, 256, 0};
        rows[6] = '{0,   1'b1, 0,   0};
        rows[7] = '{30,  1'b1, 30,  1};

        // Reset with a source already offering data.
        reset_n = 1'b0; data_valid = 1'b1; data_in = 16'hABCD; flush = 1'b0; fx2_flagb = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_slwr", 32'(fx2_slwr), 32'd1);
        check("rst_pkt_end", 32'(fx2_pkt_end), 32'd1);
        check("rst_faddr", 32'(fx2_faddr), 32'd2);
        check("rst_slrd", 32'(fx2_slrd), 32'd1);
        check("rst_sloe", 32'(fx2_sloe), 32'd1);
        check("rst_slcs", 32'(fx2_slcs), 32'd0);
        check("rst_fdata", 32'(fx2_fdata), 32'd0);
        check("rst_data_ready", 32'(data_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1; data_valid = 1'b0;
        @(negedge clk);
        check("ready_before_first_edge", 32'(data_ready), 32'd0);
        @(posedge clk);
        #1;
        check("ready_after_first_edge", 32'(data_ready), 32'd1);

        // Packet scenario table.
        for (int r = 0; r < NROWS; r++) begin
            w0 = n_wr; p0 = n_pe;
            for (int i = 0; i < rows[r].n; i++) src_q.push_back(16'($urandom));
            run_until_idle($sformatf("row%0d", r));
            if (rows[r].fl) begin
                flush = 1'b1;
                cycle(); cycle(); cycle();
                run_until_idle($sformatf("row%0d_flush", r));
            end
            repeat (6) cycle();
            check($sformatf("row%0d_writes", r), 32'(n_wr - w0), 32'(rows[r].exp_wr));
            check($sformatf("row%0d_pkt_ends", r), 32'(n_pe - p0), 32'(rows[r].exp_pe));
        end

        // Full packet 0x0000..0x00FF with four more words queued behind it.
        w0 = n_wr; p0 = n_pe;
        for (int i = 0; i < 260; i++) src_q.push_back(16'(i));
        run_until_idle("fullpkt");
        repeat (6) cycle();
        check("fullpkt_writes", 32'(n_wr - w0), 32'd260);
        check("fullpkt_no_pkt_end", 32'(n_pe - p0), 32'd0);
        check("fullpkt_tail_open", 32'(pkt_words), 32'd4);
        flush = 1'b1;
        cycle();
        run_until_idle("fullpkt_flush");
        repeat (6) cycle();
        check("fullpkt_tail_commit", 32'(n_pe - p0), 32'd1);

        // Backpressure: FX2 full for 20 cycles after 10 writes.
        w0 = n_wr; p0 = n_pe;
        for (int i = 0; i < 40; i++) src_q.push_back(16'h1000 + 16'(i));
        guard = 0;
        while (n_wr - w0 < 10 && guard < 500) begin
            cycle();
            guard++;
        end
        check("bp_first_writes_seen", 32'(guard < 500), 32'd1);
        fx2_flagb = 1'b0;
        stall_wr = 0; seen_low = 0;
        for (int i = 0; i < 20; i++) begin
            guard = n_wr;
            cycle();
            if (i >= 3 && n_wr != guard) stall_wr++;
            if (!data_ready) seen_low = 1;
        end
        check("bp_no_write_while_full", 32'(stall_wr), 32'd0);
        check("bp_buffer_fills", 32'(seen_low), 32'd1);
        fx2_flagb = 1'b1;
        run_until_idle("bp");
        flush = 1'b1;
        cycle();
        run_until_idle("bp_flush");
        repeat (6) cycle();
        check("bp_total_writes", 32'(n_wr - w0), 32'd40);
        check("bp_pkt_end", 32'(n_pe - p0), 32'd1);

        // Partial packet left idle: committed only by the timeout feature.
        w0 = n_wr; p0 = n_pe;
        for (int i = 0; i < 3; i++) src_q.push_back(16'h2000 + 16'(i));
        repeat (60) cycle();
        check("idle_writes", 32'(n_wr - w0), 32'd3);
        check("idle_pkt_end", 32'(n_pe - p0), 32'(TO_PKTS));
        flush = 1'b1;
        cycle();
        run_until_idle("idle_flush");
        repeat (6) cycle();
        check("idle_packet_closed", 32'(pkt_words), 32'd0);

        // Randomized traffic, flag stalls and flushes.
        w0 = n_wr;
        for (int c = 0; c < 2500; c++) begin
            if (src_q.size() < 4 && $urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 20)) src_q.push_back(16'($urandom));
            src_en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 19) == 0) fx2_flagb = ~fx2_flagb;
            else if (!fx2_flagb && $urandom_range(0, 5) == 0) fx2_flagb = 1'b1;
            if ($urandom_range(0, 149) == 0) flush = 1'b1;
            cycle();
        end
        src_en = 1'b1; fx2_flagb = 1'b1;
        run_until_idle("rand_drain");
        flush = 1'b1;
        cycle();
        run_until_idle("rand_flush");
        repeat (6) cycle();
        check("rand_all_words_written", 32'(sb_q.size()), 32'd0);
        check("rand_last_packet_closed", 32'(pkt_words), 32'd0);
        check("rand_traffic_flowed", 32'(n_wr - w0 > 300), 32'd1);

        // Reset asserted in the middle of a packet.
        w0 = n_wr;
        for (int i = 0; i < 20; i++) src_q.push_back(16'h3000 + 16'(i));
        guard = 0;
        while (n_wr - w0 < 3 && guard < 200) begin
            cycle();
            guard++;
        end
        check("midrst_writes_started", 32'(guard < 200), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_slwr", 32'(fx2_slwr), 32'd1);
        check("midrst_pkt_end", 32'(fx2_pkt_end), 32'd1);
        check("midrst_fdata", 32'(fx2_fdata), 32'd0);
        check("midrst_data_ready", 32'(data_ready), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        src_q.delete();
        data_valid = 1'b0;
        repeat (3) cycle();
        reset_n = 1'b1;
        w0 = n_wr; p0 = n_pe;
        repeat (30) cycle();
        check("midrst_data_dropped", 32'(n_wr - w0), 32'd0);
        check("midrst_no_pkt_end", 32'(n_pe - p0), 32'd0);
        check("midrst_idle", 32'(busy), 32'd0);
        check("midrst_ready", 32'(data_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
